// File: rtl/rle_row_encoder.sv
// Run-length encoder for one binary mask row: emits (start, end) column pairs into the
// even/odd run-code banks, then two END_MARK terminators, then pulses row_done.
module rle_row_encoder #(
    parameter int WIDTH    = 1024,
    parameter int DEPTH    = 1040,
    parameter int END_MARK = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        row_start,
    input  logic        row_odd,
    input  logic        pix_valid,
    input  logic [10:0] pix_col,
    input  logic        pix_mask,
    output logic        we0,
    output logic        we1,
    output logic [10:0] waddr,
    output logic [10:0] wdata,
    output logic [10:0] wr_count,
    output logic        row_done,
    output logic [9:0]  run_count,
    output logic        overflow,
    output logic        row_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_CLOSE,
        S_TERM1,
        S_TERM2,
        S_DONE
    } state_t;

    localparam logic [10:0] L_LAST_COL  = 11'(WIDTH - 1);
    localparam logic [10:0] L_IND_LIMIT = 11'(DEPTH - 4);  // room for start, end and both terminators
    localparam logic [10:0] L_END_MARK  = 11'(END_MARK);

    state_t      r_state;
    state_t      w_next_state;
    logic [10:0] r_ind;
    logic        r_prev_mask;
    logic        r_run_open;
    logic        r_parity;
    logic        r_overflow;
    logic [9:0]  r_run_count;
    logic        r_we0;
    logic        r_we1;
    logic [10:0] r_waddr;
    logic [10:0] r_wdata;
    logic        r_row_err;

    logic        w_accept;
    logic        w_ignored;
    logic        w_wr;
    logic [10:0] w_wdata;
    logic        w_prev_mask;
    logic        w_run_open;
    logic        w_run_inc;
    logic        w_set_ovf;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ignored    = 1'b0;
        w_wr         = 1'b0;
        w_wdata      = '0;
        w_prev_mask  = r_prev_mask;
        w_run_open   = r_run_open;
        w_run_inc    = 1'b0;
        w_set_ovf    = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (row_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ROW;
                end else if (r_state == S_DONE) begin
                    w_next_state = S_IDLE;
                end
            end
            S_ROW: begin
                if (row_start) begin
                    w_accept = 1'b1;
                end else if (pix_valid) begin
                    w_prev_mask = pix_mask;
                    if (!r_prev_mask && pix_mask) begin
                        // A dropped run leaves run_open low, so its falling edge writes nothing.
                        if (r_ind <= L_IND_LIMIT) begin
                            w_wr       = 1'b1;
                            w_wdata    = pix_col;
                            w_run_open = 1'b1;
                        end else begin
                            w_set_ovf = 1'b1;
                        end
                    end else if (r_prev_mask && !pix_mask && r_run_open) begin
                        w_wr       = 1'b1;
                        w_wdata    = pix_col - 11'd1;
                        w_run_open = 1'b0;
                        w_run_inc  = 1'b1;
                    end
                    if (pix_col == L_LAST_COL) begin
                        w_next_state = S_CLOSE;
                    end
                end
            end
            S_CLOSE: begin
                w_ignored = row_start;
                if (r_run_open) begin
                    w_wr       = 1'b1;
                    w_wdata    = L_LAST_COL;
                    w_run_open = 1'b0;
                    w_run_inc  = 1'b1;
                end
                w_next_state = S_TERM1;
            end
            S_TERM1: begin
                w_ignored    = row_start;
                w_wr         = 1'b1;
                w_wdata      = L_END_MARK;
                w_next_state = S_TERM2;
            end
            S_TERM2: begin
                w_ignored    = row_start;
                w_wr         = 1'b1;
                w_wdata      = L_END_MARK;
                w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ind       <= '0;
            r_prev_mask <= 1'b0;
            r_run_open  <= 1'b0;
            r_parity    <= 1'b0;
            r_overflow  <= 1'b0;
            r_run_count <= '0;
            r_we0       <= 1'b0;
            r_we1       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_row_err   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_row_err <= w_ignored;
            r_we0     <= w_wr & ~r_parity;
            r_we1     <= w_wr & r_parity;
            if (w_wr) begin
                r_waddr <= r_ind;
                r_wdata <= w_wdata;
            end
            if (w_accept) begin
                r_parity    <= row_odd;
                r_ind       <= '0;
                r_prev_mask <= 1'b0;
                r_run_open  <= 1'b0;
                r_run_count <= '0;
                r_overflow  <= 1'b0;
            end else begin
                r_prev_mask <= w_prev_mask;
                r_run_open  <= w_run_open;
                if (w_wr)      r_ind       <= r_ind + 11'd1;
                if (w_run_inc) r_run_count <= r_run_count + 10'd1;
                if (w_set_ovf) r_overflow  <= 1'b1;
            end
        end
    end

    assign we0       = r_we0;
    assign we1       = r_we1;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign wr_count  = r_ind;
    assign row_done  = (r_state == S_DONE);
    assign run_count = r_run_count;
    assign overflow  = r_overflow;
    assign row_err   = r_row_err;

endmodule

// File: tb/tb_rle_row_encoder.sv
// Scoreboard bench: rows are generated as whole-row masks, a run-list model predicts every
// bank write, row_done and row_err with its cycle, and a negedge monitor consumes them.
module tb_rle_row_encoder;

    localparam int WIDTH    = 1024;
    localparam int DEPTH    = 256;  // small bank so a dense row overflows
    localparam int END_MARK = 2047;

    typedef struct {
        int cyc;
        bit bank;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int cyc;
        int runs;
        bit ovf;
    } done_t;

    logic        clk;
    logic        rst;
    logic        row_start;
    logic        row_odd;
    logic        pix_valid;
    logic [10:0] pix_col;
    logic        pix_mask;
    logic        we0;
    logic        we1;
    logic [10:0] waddr;
    logic [10:0] wdata;
    logic [10:0] wr_count;
    logic        row_done;
    logic [9:0]  run_count;
    logic        overflow;
    logic        row_err;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    mask[WIDTH];
    int    gap[WIDTH];
    wr_t   wq[$];
    done_t dq[$];
    int    eq[$];
    wr_t   mon_w;
    done_t mon_d;
    int    mon_e;

    rle_row_encoder #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .END_MARK(END_MARK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_start(row_start),
        .row_odd  (row_odd),
        .pix_valid(pix_valid),
        .pix_col  (pix_col),
        .pix_mask (pix_mask),
        .we0      (we0),
        .we1      (we1),
        .waddr    (waddr),
        .wdata    (wdata),
        .wr_count (wr_count),
        .row_done (row_done),
        .run_count(run_count),
        .overflow (overflow),
        .row_err  (row_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mask();
        for (int c = 0; c < WIDTH; c++) mask[c] = 1'b0;
    endtask

    task automatic random_mask(input int flip_pct);
        bit m;
        m = 1'($urandom_range(0, 1));
        for (int c = 0; c < WIDTH; c++) begin
            if (int'($urandom_range(0, 99)) < flip_pct) m = ~m;
            mask[c] = m;
        end
    endtask

    task automatic check_outputs_zero();
        check("rst_we0", 32'(we0), 0);
        check("rst_we1", 32'(we1), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        check("rst_row_done", 32'(row_done), 0);
        check("rst_run_count", 32'(run_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_row_err", 32'(row_err), 0);
    endtask

    // Issues one row. abort_col >= 0 stops driving at that column (restart/reset follows);
    // err_t1 pulses row_start while the encoder writes the first terminator.
    task automatic drive_row(input bit parity, input int abort_col, input bit err_t1, input int tail);
        int off[WIDTH];
        int data_q[$];
        int trig_q[$];
        int slot, b, last, lim, k, s, t;
        bit ovf;
        wr_t w;
        done_t d;

        slot = 0;
        for (int c = 0; c < WIDTH; c++) begin
            gap[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            slot += gap[c] + 1;
            off[c] = slot;
        end
        lim = (abort_col >= 0) ? abort_col : WIDTH + 3;

        step();
        b = cyc;
        last = b + off[WIDTH-1];
        row_start = 1'b1;
        row_odd   = parity;
        pix_valid = 1'b0;

        // Reference: list the maximal runs of ones; run k fits while 2k <= DEPTH-4.
        k = 0;
        s = 0;
        ovf = 1'b0;
        for (int c = 0; c < WIDTH; c++) begin
            if (mask[c] && (c == 0 || !mask[c-1])) s = c;
            if (mask[c] && (c == WIDTH - 1 || !mask[c+1])) begin
                if (2 * k <= DEPTH - 4) begin
                    data_q.push_back(s);
                    trig_q.push_back(s);
                    data_q.push_back(c);
                    trig_q.push_back((c == WIDTH - 1) ? WIDTH : c + 1);
                    k++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        data_q.push_back(END_MARK);
        trig_q.push_back(WIDTH + 1);
        data_q.push_back(END_MARK);
        trig_q.push_back(WIDTH + 2);

        for (int i = 0; i < data_q.size(); i++) begin
            t = trig_q[i];
            if (t < lim) begin
                w.cyc  = (t < WIDTH) ? b + off[t] + 1 : last + 2 + (t - WIDTH);
                w.bank = parity;
                w.addr = i;
                w.data = data_q[i];
                wq.push_back(w);
            end
        end
        if (abort_col < 0) begin
            d.cyc  = last + 4;
            d.runs = k;
            d.ovf  = ovf;
            dq.push_back(d);
            if (err_t1) eq.push_back(last + 3);
        end

        for (int c = 0; c < WIDTH; c++) begin
            if (c == abort_col) return;
            for (int g = 0; g < gap[c]; g++) begin
                step();
                row_start = 1'b0;
                row_odd   = 1'($urandom_range(0, 1));
                pix_valid = 1'b0;
                pix_col   = 11'($urandom_range(0, 2047));
                pix_mask  = 1'($urandom_range(0, 1));
            end
            step();
            row_start = 1'b0;
            pix_valid = 1'b1;
            pix_col   = 11'(c);
            pix_mask  = mask[c];
        end
        for (int i = 1; i <= tail; i++) begin
            step();
            row_start = err_t1 && (i == 2);
            row_odd   = ~parity;
            pix_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (we0 || we1) begin
                check("we_onehot", 32'(we0 & we1), 0);
                if (wq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mon_w = wq.pop_front();
                    check("w_bank", 32'(we1), 32'(mon_w.bank));
                    check("w_addr", 32'(waddr), mon_w.addr);
                    check("w_data", 32'(wdata), mon_w.data);
                    check("w_cycle", cyc, mon_w.cyc);
                    check("wr_count", 32'(wr_count), mon_w.addr + 1);
                end
            end
            if (row_done) begin
                if (dq.size() == 0) begin
                    check("unexpected_row_done", 1, 0);
                end else begin
                    mon_d = dq.pop_front();
                    check("done_cycle", cyc, mon_d.cyc);
                    check("run_count", 32'(run_count), mon_d.runs);
                    check("overflow", 32'(overflow), 32'(mon_d.ovf));
                end
            end
            if (row_err) begin
                if (eq.size() == 0) begin
                    check("unexpected_row_err", 1, 0);
                end else begin
                    mon_e = eq.pop_front();
                    check("row_err_cycle", cyc, mon_e);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        row_start = 1'b0;
        row_odd   = 1'b0;
        pix_valid = 1'b0;
        pix_col   = '0;
        pix_mask  = 1'b0;
        repeat (3) step();
        check_outputs_zero();
        rst = 1'b0;
        repeat (2) step();

        clear_mask();
        for (int c = 10; c <= 19; c++) mask[c] = 1'b1;
        drive_row(1'b0, -1, 1'b0, 8);

        clear_mask();
        mask[0] = 1'b1;
        for (int c = 1020; c <= 1023; c++) mask[c] = 1'b1;
        drive_row(1'b1, -1, 1'b0, 8);

        clear_mask();
        mask[WIDTH-1] = 1'b1;
        drive_row(1'b0, -1, 1'b0, 8);

        for (int c = 0; c < WIDTH; c++) mask[c] = (c % 2 == 0);
        drive_row(1'b1, -1, 1'b0, 8);

        random_mask(8);
        drive_row(1'b0, -1, 1'b1, 8);

        random_mask(5);
        drive_row(1'b1, -1, 1'b0, 3);
        random_mask(12);
        drive_row(1'b0, -1, 1'b0, 8);

        random_mask(10);
        drive_row(1'b1, 300, 1'b0, 0);
        random_mask(6);
        drive_row(1'b1, -1, 1'b0, 8);

        random_mask(10);
        drive_row(1'b0, 500, 1'b0, 0);
        step();
        pix_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check_outputs_zero();
        step();
        rst = 1'b0;
        step();
        clear_mask();
        drive_row(1'b0, -1, 1'b0, 8);

        for (int r = 0; r < 4; r++) begin
            random_mask(int'($urandom_range(1, 40)));
            drive_row(1'($urandom_range(0, 1)), -1, 1'b0, 8);
        end

        repeat (5) step();
        check("pending_writes", wq.size(), 0);
        check("pending_row_done", dq.size(), 0);
        check("pending_row_err", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
